// File: rtl/piradspi_subordinate.sv
// rtl/piradspi_subordinate.sv - SPI subordinate with AXI-stream rx/tx word ports
module piradspi_subordinate #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_tdata,
    output logic                  rx_tvalid,
    input  logic                  rx_tready,
    input  logic [DATA_WIDTH-1:0] tx_tdata,
    input  logic                  tx_tvalid,
    output logic                  tx_tready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    input  logic                  err_clear,
    output logic                  frame_active,
    output logic [15:0]           word_count
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  csn_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_d;
    logic                    csn_d;
    logic [SYNC_STAGES:0]    settle;
    logic                    armed;
    logic                    cpol_l;
    logic                    cpha_l;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [CW-1:0]           bit_cnt;

    logic sclk_s;
    logic csn_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic csn_fall;
    logic csn_rise;
    logic word_done;
    logic [DATA_WIDTH-1:0] rx_word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // A falling csn only starts a frame once csn has been seen high after reset,
    // so a select already held low at reset release is not mistaken for a new frame.
    assign csn_fall = armed & csn_d & ~csn_s;
    assign csn_rise = ~csn_d & csn_s;

    assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;

    assign rx_word   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign word_done = (state == ST_SHIFT) && sample_edge && (bit_cnt == LAST_BIT) && !csn_rise;

    // The word is consumed during the single LOAD cycle, so the ready pulse is
    // exactly that cycle; an aborting csn edge in the same cycle consumes nothing.
    assign tx_tready = (state == ST_LOAD) && tx_tvalid && !csn_rise;
    assign miso      = tx_shift[DATA_WIDTH-1];
    assign miso_oe   = frame_active;

    // Synchronize the asynchronous SPI pins and keep one previous sample for edge detection
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
        end
    end

    // Arm frame detection once the synchronizers hold real pin data and csn is high
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && csn_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM with shift registers, rx handshake, word counter and sticky flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            cpol_l       <= 1'b0;
            cpha_l       <= 1'b0;
            tx_shift     <= '1;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            rx_tdata     <= '0;
            rx_tvalid    <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_active <= 1'b0;
            word_count   <= '0;
        end else begin
            // Clearing comes first so a same-cycle setting event below wins.
            if (err_clear) begin
                rx_overrun  <= 1'b0;
                tx_underrun <= 1'b0;
            end

            if (rx_tvalid && rx_tready) begin
                rx_tvalid <= 1'b0;
            end

            if (word_done) begin
                if (!rx_tvalid || rx_tready) begin
                    rx_tdata  <= rx_word;
                    rx_tvalid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
                if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end

            if (csn_rise) begin
                // Abort: partial rx bits and any loaded tx word are dropped.
                state        <= ST_IDLE;
                frame_active <= 1'b0;
                bit_cnt      <= '0;
                rx_shift     <= '0;
                tx_shift     <= '1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csn_fall) begin
                            state        <= ST_LOAD;
                            cpol_l       <= cpol;
                            cpha_l       <= cpha;
                            frame_active <= 1'b1;
                            word_count   <= '0;
                            bit_cnt      <= '0;
                            rx_shift     <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (tx_tvalid) begin
                            tx_shift <= tx_tdata;
                        end else begin
                            tx_shift    <= '1;
                            tx_underrun <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (sample_edge) begin
                            rx_shift <= rx_word;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= ST_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        // A shift edge before any sample of this word is skipped: the
                        // freshly loaded MSB must stay on miso until it has been sampled.
                        if (shift_edge && (bit_cnt != '0)) begin
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b1};
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piradspi_subordinate.sv
// tb/tb_piradspi_subordinate.sv - self-checking bench for piradspi_subordinate
module tb_piradspi_subordinate;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         aclk = 1'b0;
    logic         areset;
    logic         cpol, cpha, sclk, csn, mosi;
    logic         miso, miso_oe;
    logic [W-1:0] rx_tdata;
    logic         rx_tvalid, rx_tready;
    logic [W-1:0] tx_tdata;
    logic         tx_tvalid, tx_tready;
    logic         rx_overrun, tx_underrun, err_clear, frame_active;
    logic [15:0]  word_count;

    int           checks    = 0;
    int           failures  = 0;
    int           tx_pulses = 0;
    logic [W-1:0] rx_exp[$];
    logic [W-1:0] mon_exp;

    piradspi_subordinate #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .aclk(aclk), .areset(areset), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .err_clear(err_clear),
        .frame_active(frame_active), .word_count(word_count)
    );

    always #5 aclk = ~aclk;

    // Scoreboard side: every accepted rx word is popped and compared
    always @(negedge aclk) begin
        if (tx_tready) tx_pulses++;
        if (!areset && rx_tvalid && rx_tready) begin
            checks++;
            if (rx_exp.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected got=%h exp=none", rx_tdata);
            end else begin
                mon_exp = rx_exp.pop_front();
                if (rx_tdata !== mon_exp) begin
                    failures++;
                    $display("FAIL rx_word got=%h exp=%h", rx_tdata, mon_exp);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        wait_cyc(1);
        err_clear = 1'b0;
        wait_cyc(1);
    endtask

    // Manager side of nbits bit periods, MSB first; returns the miso bits it sampled
    task automatic spi_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        mi = '1;
        for (int i = W - 1; i >= W - nbits; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                wait_cyc(HALF);
                mi[i] = miso;
                sclk = ~cpol;
                wait_cyc(HALF);
                sclk = cpol;
            end else begin
                wait_cyc(HALF);
                sclk = ~cpol;
                mosi = mo[i];
                wait_cyc(HALF);
                mi[i] = miso;
                sclk = cpol;
            end
        end
    endtask

    // One frame of nw words; a feeder process advances tx words on each ready pulse
    task automatic do_frame(input logic c_pol, input logic c_pha, input int nw,
                            input logic [2*W-1:0] m, input logic [2*W-1:0] t,
                            input logic tx_en, output logic [2*W-1:0] got);
        logic [W-1:0] w;
        got  = '1;
        cpol = c_pol;
        cpha = c_pha;
        sclk = c_pol;
        wait_cyc(HALF);
        tx_tdata  = t[W-1:0];
        tx_tvalid = tx_en;
        csn = 1'b0;
        fork
            begin
                for (int k = 0; k < nw; k++) begin
                    wait_cyc(HALF);
                    spi_bits(m[k*W +: W], W, w);
                    got[k*W +: W] = w;
                end
                wait_cyc(HALF);
            end
            begin
                int cyc;
                if (tx_en) begin
                    for (int j = 0; j < nw; j++) begin
                        cyc = 0;
                        do begin
                            @(negedge aclk);
                            cyc++;
                        end while (!tx_tready && cyc < 4000);
                        if (!tx_tready) begin
                            checks++;
                            failures++;
                            $display("FAIL tx_feed_timeout got=0 exp=1");
                        end
                        @(posedge aclk);
                        #1;
                        if (j + 1 < nw) tx_tdata = t[(j+1)*W +: W];
                        else tx_tvalid = 1'b0;
                    end
                end
            end
        join
        csn = 1'b1;
        tx_tvalid = 1'b0;
        wait_cyc(2 * HALF);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cpol = 0; cpha = 0; sclk = 0; csn = 1; mosi = 0;
        rx_tready = 1; tx_tdata = 8'h55; tx_tvalid = 1; err_clear = 0;
        wait_cyc(3);
        checks++;
        if ({miso, miso_oe, rx_tvalid, tx_tready, rx_overrun, tx_underrun, frame_active} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1000000",
                     {miso, miso_oe, rx_tvalid, tx_tready, rx_overrun, tx_underrun, frame_active});
        end
        checks++;
        if (rx_tdata !== 8'h00) begin failures++; $display("FAIL reset_rx_tdata got=%h exp=00", rx_tdata); end
        checks++;
        if (word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        tx_tvalid = 0;
        areset = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_mode0();
        logic [2*W-1:0] got;
        int p0;
        rx_tready = 1;
        rx_exp.push_back(8'hA5);
        p0 = tx_pulses;
        do_frame(0, 0, 1, {8'h00, 8'hA5}, {8'h00, 8'h3C}, 1, got);
        checks++;
        if (got[W-1:0] !== 8'h3C) begin failures++; $display("FAIL mode0_miso got=%h exp=3c", got[W-1:0]); end
        checks++;
        if (tx_pulses - p0 !== 1) begin failures++; $display("FAIL mode0_tready_pulses got=%0d exp=1", tx_pulses - p0); end
        checks++;
        if (word_count !== 16'd1) begin failures++; $display("FAIL mode0_word_count got=%0d exp=1", word_count); end
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL mode0_rx_pending got=%0d exp=0", rx_exp.size()); end
        checks++;
        if ({frame_active, miso_oe, miso} !== 3'b001) begin
            failures++; $display("FAIL mode0_idle_pins got=%b exp=001", {frame_active, miso_oe, miso});
        end
    endtask

    task automatic test_mode3_two_words();
        logic [2*W-1:0] got;
        int p0;
        rx_tready = 1;
        rx_exp.push_back(8'h12);
        rx_exp.push_back(8'h34);
        p0 = tx_pulses;
        do_frame(1, 1, 2, {8'h34, 8'h12}, {8'h0F, 8'hF0}, 1, got);
        checks++;
        if (got !== 16'h0FF0) begin failures++; $display("FAIL mode3_miso got=%h exp=0ff0", got); end
        checks++;
        if (tx_pulses - p0 !== 2) begin failures++; $display("FAIL mode3_tready_pulses got=%0d exp=2", tx_pulses - p0); end
        checks++;
        if (word_count !== 16'd2) begin failures++; $display("FAIL mode3_word_count got=%0d exp=2", word_count); end
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL mode3_rx_pending got=%0d exp=0", rx_exp.size()); end
    endtask

    task automatic test_underrun();
        logic [2*W-1:0] got;
        pulse_err_clear();
        checks++;
        if ({rx_overrun, tx_underrun} !== 2'b00) begin
            failures++; $display("FAIL underrun_pre_clear got=%b exp=00", {rx_overrun, tx_underrun});
        end
        rx_tready = 1;
        rx_exp.push_back(8'h66);
        do_frame(0, 1, 1, {8'h00, 8'h66}, {8'h00, 8'h00}, 0, got);
        checks++;
        if (got[W-1:0] !== 8'hFF) begin failures++; $display("FAIL underrun_miso got=%h exp=ff", got[W-1:0]); end
        checks++;
        if (tx_underrun !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b exp=1", tx_underrun); end
        pulse_err_clear();
        checks++;
        if (tx_underrun !== 1'b0) begin failures++; $display("FAIL underrun_cleared got=%b exp=0", tx_underrun); end
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL underrun_rx_pending got=%0d exp=0", rx_exp.size()); end
    endtask

    task automatic test_overrun();
        logic [2*W-1:0] got;
        rx_tready = 0;
        rx_exp.push_back(8'h11);
        do_frame(0, 0, 2, {8'h22, 8'h11}, {8'hAA, 8'h55}, 1, got);
        checks++;
        if (rx_tvalid !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%b exp=1", rx_tvalid); end
        checks++;
        if (rx_tdata !== 8'h11) begin failures++; $display("FAIL overrun_tdata got=%h exp=11", rx_tdata); end
        checks++;
        if (rx_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", rx_overrun); end
        checks++;
        if (word_count !== 16'd2) begin failures++; $display("FAIL overrun_word_count got=%0d exp=2", word_count); end
        rx_tready = 1;
        wait_cyc(4);
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL overrun_rx_pending got=%0d exp=0", rx_exp.size()); end
        checks++;
        if (rx_tvalid !== 1'b0) begin failures++; $display("FAIL overrun_valid_drop got=%b exp=0", rx_tvalid); end
        pulse_err_clear();
    endtask

    task automatic test_abort();
        logic [W-1:0] w;
        logic [2*W-1:0] got;
        rx_tready = 1;
        cpol = 0; cpha = 0; sclk = 0;
        wait_cyc(HALF);
        tx_tdata = 8'h99; tx_tvalid = 1;
        csn = 0;
        wait_cyc(HALF);
        spi_bits(8'hE7, 5, w);
        wait_cyc(HALF);
        csn = 1;
        tx_tvalid = 0;
        wait_cyc(2 * HALF);
        checks++;
        if (rx_tvalid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", rx_tvalid); end
        checks++;
        if (word_count !== 16'd0) begin failures++; $display("FAIL abort_word_count got=%0d exp=0", word_count); end
        rx_exp.push_back(8'h5A);
        do_frame(0, 0, 1, {8'h00, 8'h5A}, {8'h00, 8'h81}, 1, got);
        checks++;
        if (got[W-1:0] !== 8'h81) begin failures++; $display("FAIL abort_next_miso got=%h exp=81", got[W-1:0]); end
        checks++;
        if (word_count !== 16'd1) begin failures++; $display("FAIL abort_next_word_count got=%0d exp=1", word_count); end
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL abort_rx_pending got=%0d exp=0", rx_exp.size()); end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] w;
        logic [2*W-1:0] got;
        rx_tready = 1;
        cpol = 0; cpha = 0; sclk = 0;
        wait_cyc(HALF);
        tx_tdata = 8'h77; tx_tvalid = 1;
        csn = 0;
        wait_cyc(HALF);
        spi_bits(8'hC3, 3, w);
        #3;
        areset = 1'b1;
        #1;
        checks++;
        if ({miso, miso_oe, rx_tvalid, tx_tready, rx_overrun, tx_underrun, frame_active} !== 7'b1000000) begin
            failures++;
            $display("FAIL midreset_flags got=%b exp=1000000",
                     {miso, miso_oe, rx_tvalid, tx_tready, rx_overrun, tx_underrun, frame_active});
        end
        checks++;
        if (rx_tdata !== 8'h00) begin failures++; $display("FAIL midreset_rx_tdata got=%h exp=00", rx_tdata); end
        checks++;
        if (word_count !== 16'd0) begin failures++; $display("FAIL midreset_word_count got=%0d exp=0", word_count); end
        tx_tvalid = 0;
        wait_cyc(3);
        areset = 1'b0;
        wait_cyc(12);
        checks++;
        if ({frame_active, miso} !== 2'b01) begin
            failures++; $display("FAIL release_csn_low got=%b exp=01", {frame_active, miso});
        end
        csn = 1;
        wait_cyc(6);
        rx_exp.push_back(8'hC3);
        do_frame(0, 0, 1, {8'h00, 8'hC3}, {8'h00, 8'h5C}, 1, got);
        checks++;
        if (got[W-1:0] !== 8'h5C) begin failures++; $display("FAIL postreset_miso got=%h exp=5c", got[W-1:0]); end
        checks++;
        if (word_count !== 16'd1) begin failures++; $display("FAIL postreset_word_count got=%0d exp=1", word_count); end
        checks++;
        if (rx_exp.size() !== 0) begin failures++; $display("FAIL postreset_rx_pending got=%0d exp=0", rx_exp.size()); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_two_words();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_word();
        wait_cyc(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piradspi_subordinate.md
PIRADSPI_SUBORDINATE -- requirements
Module: piradspi_subordinate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the SPI word length in bits (range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for sclk, csn and mosi (minimum 2).
REQ-003 SHALL have ports, clock and reset first:
- aclk  in  1  single clock for the whole block.
- areset  in  1  reset, asynchronous and active-high.
- cpol  in  1  SPI clock polarity; captured at frame start.
- cpha  in  1  SPI clock phase; captured at frame start.
- sclk  in  1  SPI clock from the manager; asynchronous to aclk.
- csn  in  1  chip select, active-low; asynchronous to aclk.
- mosi  in  1  serial data from the manager.
- miso  out  1  serial data to the manager, MSB first.
- miso_oe  out  1  output enable for the miso pad; high while a frame is active.
- rx_tdata  out  DATA_WIDTH  received word (AXI-stream manager).
- rx_tvalid  out  1  received word valid.
- rx_tready  in  1  downstream accepts the word.
- tx_tdata  in  DATA_WIDTH  word to transmit (AXI-stream subordinate).
- tx_tvalid  in  1  transmit word valid.
- tx_tready  out  1  one-cycle pulse when tx_tdata is consumed.
- rx_overrun  out  1  sticky flag: a received word was dropped.
- tx_underrun  out  1  sticky flag: a word was needed while tx_tvalid was low.
- err_clear  in  1  one-cycle pulse that clears both sticky flags.
- frame_active  out  1  synchronized csn is low.
- word_count  out  16  number of complete words received in the current or last frame.

Function
REQ-004 SHALL pass sclk, csn and mosi through SYNC_STAGES flip-flops, then one edge-detect register; all decisions SHALL use the synchronized values. The supported sclk frequency is at most aclk/8.
REQ-005 SHALL implement the states IDLE, LOAD and SHIFT:
- IDLE to LOAD on a synchronized csn falling edge.
- LOAD to SHIFT after one cycle.
- SHIFT to LOAD after the DATA_WIDTH-th sample edge.
- Any state to IDLE on a synchronized csn rising edge.
REQ-006 SHALL, at the csn falling edge, latch cpol and cpha; changes to these inputs during a frame SHALL be ignored.
REQ-007 SHALL define the sclk edges using the latched cpol:
- The leading edge is sclk rising when cpol=0, falling when cpol=1.
- The sample edge is the leading edge when cpha=0, the trailing edge when cpha=1.
- The shift edge is the other one.
REQ-008 SHALL, in LOAD, take tx_tdata into the tx shift register if tx_tvalid=1 and pulse tx_tready for exactly one cycle.
REQ-009 SHALL, in LOAD with tx_tvalid=0, load all-ones instead, hold tx_tready low and set tx_underrun.
REQ-010 SHALL drive miso from the tx shift register MSB. The MSB SHALL be valid by the end of LOAD, so cpha=0 mode has bit 7 (for W=8) present before the first edge.
REQ-011 SHALL shift the tx register left by one on each shift edge. For cpha=1, the first shift edge of each word SHALL NOT shift, because the MSB is already presented.
REQ-012 SHALL shift mosi into the LSB of the rx shift register on each sample edge and increment a bit counter of width clog2(DATA_WIDTH)+1.
REQ-013 SHALL, on the DATA_WIDTH-th sample edge when rx_tvalid=0, do the following on the next aclk cycle:
- Present the word on rx_tdata.
- Assert rx_tvalid.
- Increment word_count, saturating at 0xFFFF.
REQ-014 SHALL, on word completion when rx_tvalid=1 and rx_tready=0, keep the old word, discard the new word and set rx_overrun; word_count SHALL still increment.
REQ-015 SHALL hold rx_tvalid and rx_tdata stable until rx_tvalid and rx_tready are both high, then drop rx_tvalid on the next cycle. A word completing in the same cycle as acceptance SHALL be accepted, not flagged as overrun.
REQ-016 SHALL, on a csn rising edge mid-word, discard the partial rx bits, reset the bit counter and not consume any tx word. An already-loaded tx word SHALL be discarded.
REQ-017 SHALL clear word_count to 0 at each csn falling edge.
REQ-018 SHALL drive miso_oe = frame_active and drive miso=1 while IDLE.
REQ-019 SHALL clear the sticky flags on err_clear. A setting event in the same cycle as err_clear SHALL take priority, leaving the flag set.
REQ-020 SHALL ignore sclk edges while in IDLE or LOAD.

Reset
REQ-021 SHALL, while areset=1, asynchronously force the following:
- State to IDLE.
- Synchronizers: sclk stages to 0, csn stages to 1.
- miso=1, miso_oe=0, rx_tvalid=0, rx_tdata=0, tx_tready=0.
- rx_overrun=0, tx_underrun=0, frame_active=0, word_count=0.
- Latched cpol and cpha to 0.
REQ-022 SHALL, on release of areset with csn already low, not start a frame until a new csn falling edge occurs.

Verification
REQ-023 Mode 0, W=8, tx_tdata=0x3C valid, manager sends 0xA5 -> rx_tdata=0xA5 with rx_tvalid; miso bits 0,0,1,1,1,1,0,0; tx_tready pulses once; word_count=1.
REQ-024 Mode 3 (cpol=1, cpha=1), two words 0x12 and 0x34 in one frame, tx 0xF0 then 0x0F, rx_tready=1 -> rx words 0x12 then 0x34; miso carries 0xF0 then 0x0F; word_count=2.
REQ-025 tx_tvalid=0 at frame start -> miso carries 0xFF; tx_underrun=1; err_clear pulse -> tx_underrun=0.
REQ-026 rx_tready=0, two words 0x11 and 0x22 -> rx_tdata stays 0x11; rx_overrun=1; word_count=2.
REQ-027 csn rises after 5 sclk cycles -> no rx_tvalid; word_count=0; the next frame receives a full 0x5A correctly.
REQ-028 areset asserted mid-word -> all outputs at reset values within the same cycle; after release, a new frame receiving 0xC3 works correctly.
